// File: rtl/pooling_pkg.sv
// Shared types for the pooling sequencer and pooling_top: FSM states, the
// control bundle that drives the x-mux/regfile/pool unit, and a width helper.
package pooling_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pool_state_t;

  // Widest regfile address any pooling_top configuration may use.
  localparam int unsigned POOL_ADDR_W = 8;

  typedef struct packed {
    logic                   x_sel;
    logic                   pool_en;
    logic                   rf_wr_en;
    logic                   rf_wr_src;
    logic [POOL_ADDR_W-1:0] rf_rd_addr;
    logic [POOL_ADDR_W-1:0] rf_wr_addr;
  } pool_ctrl_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pooling_ctrl_counter.sv
// Modulo-MAX counter with clear; wrap flags the increment that returns to 0.
module pool_mod_counter
  import pooling_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         clr,
  output logic [clog2_min1(MAX)-1:0]   count,
  output logic                         wrap
);

  localparam int unsigned W = clog2_min1(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/pooling_ctrl.sv
// Sequencer for pooling_top: walks the row-major systolic output stream and
// folds each POOL_K x POOL_K window into one regfile entry.
module pooling_ctrl
  import pooling_pkg::*;
#(
  parameter int unsigned FMAP_W = 8,
  parameter int unsigned FMAP_H = 8,
  parameter int unsigned POOL_K = 2
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic                                     start,
  input  logic                                     in_valid,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     x_sel,
  output logic                                     pool_en,
  output logic                                     rf_wr_en,
  output logic                                     rf_wr_src,
  output logic [clog2_min1(FMAP_W/POOL_K)-1:0]     rf_rd_addr,
  output logic [clog2_min1(FMAP_W/POOL_K)-1:0]     rf_wr_addr,
  output logic                                     out_valid,
  output logic [clog2_min1(FMAP_H/POOL_K)-1:0]     out_row,
  output logic [clog2_min1(FMAP_W/POOL_K)-1:0]     out_col
);

  localparam int unsigned ADDR_W    = clog2_min1(FMAP_W / POOL_K);
  localparam int unsigned OUT_ROW_W = clog2_min1(FMAP_H / POOL_K);
  localparam int unsigned COL_W     = clog2_min1(FMAP_W);
  localparam int unsigned ROW_W     = clog2_min1(FMAP_H);
  localparam int unsigned KB        = $clog2(POOL_K);

  pool_state_t      state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_wrap, row_wrap;
  logic             accept, begin_map;
  logic [ADDR_W-1:0] win;
  logic             first_pos, last_pos;
  pool_ctrl_t       ctrl;

  assign accept    = (state == RUN) && in_valid;
  assign begin_map = (state == IDLE) && start;

  pool_mod_counter #(.MAX(FMAP_W)) u_col (
    .clk   (clk),
    .rst   (nrst),
    .inc   (accept),
    .clr   (begin_map),
    .count (col),
    .wrap  (col_wrap)
  );

  pool_mod_counter #(.MAX(FMAP_H)) u_row (
    .clk   (clk),
    .rst   (nrst),
    .inc   (col_wrap),
    .clr   (begin_map),
    .count (row),
    .wrap  (row_wrap)
  );

  // row_wrap can only fire on an accepted last-column element, so it marks the final element.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (row_wrap) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Window position: column/row within the window are the low KB bits.
  assign win       = ADDR_W'(col >> KB);
  assign first_pos = (col[KB-1:0] == '0) && (row[KB-1:0] == '0);
  assign last_pos  = (col[KB-1:0] == '1) && (row[KB-1:0] == '1);

  always_comb begin
    ctrl      = '0;
    out_valid = 1'b0;
    out_row   = '0;
    out_col   = '0;
    if (accept) begin
      ctrl.x_sel      = 1'b1;
      ctrl.rf_wr_en   = 1'b1;
      ctrl.rf_wr_src  = !first_pos;
      ctrl.pool_en    = !first_pos;
      ctrl.rf_rd_addr = POOL_ADDR_W'(win);
      ctrl.rf_wr_addr = POOL_ADDR_W'(win);
      if (last_pos) begin
        out_valid = 1'b1;
        out_row   = OUT_ROW_W'(row >> KB);
        out_col   = win;
      end
    end
  end

  assign x_sel      = ctrl.x_sel;
  assign pool_en    = ctrl.pool_en;
  assign rf_wr_en   = ctrl.rf_wr_en;
  assign rf_wr_src  = ctrl.rf_wr_src;
  assign rf_rd_addr = ADDR_W'(ctrl.rf_rd_addr);
  assign rf_wr_addr = ADDR_W'(ctrl.rf_wr_addr);

endmodule

// File: tb/tb_pooling_ctrl.sv
// Bench for pooling_ctrl: a 4x2 instance for directed sequencing cases and a
// default 8x8 instance for a full map, both checked every cycle against a model.
module tb_pooling_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance (4x2, K=2)
  logic       rst_a = 1'b1, start_a = 1'b0, iv_a = 1'b0;
  logic       a_busy, a_done, a_xs, a_pe, a_we, a_ws, a_ov;
  logic [0:0] a_rd, a_wr, a_orow, a_ocol;

  // Default instance (8x8, K=2)
  logic       rst_b = 1'b1, start_b = 1'b0, iv_b = 1'b0;
  logic       b_busy, b_done, b_xs, b_pe, b_we, b_ws, b_ov;
  logic [1:0] b_rd, b_wr, b_orow, b_ocol;

  pooling_ctrl #(.FMAP_W(4), .FMAP_H(2), .POOL_K(2)) dut_a (
    .clk(clk), .nrst(rst_a), .start(start_a), .in_valid(iv_a),
    .busy(a_busy), .done(a_done), .x_sel(a_xs), .pool_en(a_pe),
    .rf_wr_en(a_we), .rf_wr_src(a_ws), .rf_rd_addr(a_rd), .rf_wr_addr(a_wr),
    .out_valid(a_ov), .out_row(a_orow), .out_col(a_ocol)
  );

  pooling_ctrl #(.FMAP_W(8), .FMAP_H(8), .POOL_K(2)) dut_b (
    .clk(clk), .nrst(rst_b), .start(start_b), .in_valid(iv_b),
    .busy(b_busy), .done(b_done), .x_sel(b_xs), .pool_en(b_pe),
    .rf_wr_en(b_we), .rf_wr_src(b_ws), .rf_rd_addr(b_rd), .rf_wr_addr(b_wr),
    .out_valid(b_ov), .out_row(b_orow), .out_col(b_ocol)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=run 2=done, idx = elements accepted so far in the map.
  typedef struct packed {
    logic busy, done, xs, pe, we, ws, ov;
    logic [7:0] rd, wr, orow, ocol;
  } exp_t;

  function automatic exp_t model(input int w, input int h, input int k,
                                 input int ph, input int idx, input logic iv);
    exp_t e;
    int r, c;
    e = '0;
    e.busy = (ph == 1);
    e.done = (ph == 2);
    if (ph == 1 && iv) begin
      r = idx / w;
      c = idx % w;
      e.xs = 1'b1;
      e.we = 1'b1;
      e.ws = !((r % k == 0) && (c % k == 0));
      e.pe = e.ws;
      e.rd = 8'(c / k);
      e.wr = 8'(c / k);
      if ((r % k == k - 1) && (c % k == k - 1)) begin
        e.ov   = 1'b1;
        e.orow = 8'(r / k);
        e.ocol = 8'(c / k);
      end
    end
    return e;
  endfunction

  int ph_a = 0, idx_a = 0, ph_b = 0, idx_b = 0;

  always @(posedge clk) begin
    if (rst_a) begin
      ph_a <= 0; idx_a <= 0;
    end else if (ph_a == 0) begin
      if (start_a) begin ph_a <= 1; idx_a <= 0; end
    end else if (ph_a == 1) begin
      if (iv_a) begin
        if (idx_a == 4 * 2 - 1) ph_a <= 2;
        else idx_a <= idx_a + 1;
      end
    end else begin
      ph_a <= 0;
    end
    if (rst_b) begin
      ph_b <= 0; idx_b <= 0;
    end else if (ph_b == 0) begin
      if (start_b) begin ph_b <= 1; idx_b <= 0; end
    end else if (ph_b == 1) begin
      if (iv_b) begin
        if (idx_b == 8 * 8 - 1) ph_b <= 2;
        else idx_b <= idx_b + 1;
      end
    end else begin
      ph_b <= 0;
    end
  end

  task automatic cmp_dut(input string t, input exp_t e, input exp_t a,
                         input logic iv, input logic prev_done, input int nwin);
    chk({t, "_busy"},   32'(a.busy), 32'(e.busy));
    chk({t, "_done"},   32'(a.done), 32'(e.done));
    chk({t, "_x_sel"},  32'(a.xs),   32'(e.xs));
    chk({t, "_pool_en"},32'(a.pe),   32'(e.pe));
    chk({t, "_wr_en"},  32'(a.we),   32'(e.we));
    chk({t, "_wr_src"}, 32'(a.ws),   32'(e.ws));
    chk({t, "_rd_addr"},32'(a.rd),   32'(e.rd));
    chk({t, "_wr_addr"},32'(a.wr),   32'(e.wr));
    chk({t, "_out_val"},32'(a.ov),   32'(e.ov));
    chk({t, "_out_row"},32'(a.orow), 32'(e.orow));
    chk({t, "_out_col"},32'(a.ocol), 32'(e.ocol));
    chk({t, "_wren_gate"}, 32'(a.we & ~(a.busy & iv)), 32'(0));
    chk({t, "_rd_eq_wr"},  32'(a.rd), 32'(a.wr));
    chk({t, "_addr_rng"},  32'(int'(a.rd) < nwin), 32'(1));
    chk({t, "_done_1cyc"}, 32'(a.done & prev_done), 32'(0));
  endtask

  logic run_cmp = 1'b0;
  logic pd_a = 1'b0, pd_b = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_dut("a", model(4, 2, 2, ph_a, idx_a, iv_a),
              {a_busy, a_done, a_xs, a_pe, a_we, a_ws, a_ov,
               8'(a_rd), 8'(a_wr), 8'(a_orow), 8'(a_ocol)}, iv_a, pd_a, 2);
      cmp_dut("b", model(8, 8, 2, ph_b, idx_b, iv_b),
              {b_busy, b_done, b_xs, b_pe, b_we, b_ws, b_ov,
               8'(b_rd), 8'(b_wr), 8'(b_orow), 8'(b_ocol)}, iv_b, pd_b, 4);
    end
    pd_a <= a_done;
    pd_b <= b_done;
  end

  // Inputs change 1 time unit after the edge; literal checks follow 1 unit later.
  task automatic step_a(input logic r, input logic s, input logic v);
    @(posedge clk);
    #1;
    rst_a = r; start_a = s; iv_a = v;
    #1;
  endtask

  task automatic step_b(input logic r, input logic s, input logic v);
    @(posedge clk);
    #1;
    rst_b = r; start_b = s; iv_b = v;
    #1;
  endtask

  // Hand-derived per-input expectations for the 4x2 map.
  int src_tab [8] = '{0, 1, 0, 1, 1, 1, 1, 1};
  int addr_tab[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int ov_tab  [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
  int col_tab [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk_input_a(input string t, input int i);
    chk({t, "_wr_en"},   32'(a_we), 32'(1));
    chk({t, "_wr_src"},  32'(a_ws), 32'(src_tab[i]));
    chk({t, "_wr_addr"}, 32'(a_wr), 32'(addr_tab[i]));
    chk({t, "_out_val"}, 32'(a_ov), 32'(ov_tab[i]));
    chk({t, "_out_col"}, 32'(a_ocol), 32'(col_tab[i]));
    chk({t, "_busy"},    32'(a_busy), 32'(1));
  endtask

  int ov_cnt, done_cnt;

  initial begin
    step_a(1, 0, 0);
    step_b(1, 0, 0);
    step_a(1, 0, 0);
    run_cmp = 1'b1;
    chk("reset_busy", 32'(a_busy), 32'(0));
    chk("reset_done", 32'(a_done), 32'(0));
    chk("reset_wr_en", 32'(a_we), 32'(0));
    step_a(0, 0, 0);
    step_b(0, 0, 0);

    // 1: back-to-back stream
    step_a(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step_a(0, 0, 1);
      chk_input_a("t1", i);
    end
    step_a(0, 0, 0);
    chk("t1_done", 32'(a_done), 32'(1));
    chk("t1_busy_done", 32'(a_busy), 32'(0));
    step_a(0, 0, 0);
    chk("t1_done_clear", 32'(a_done), 32'(0));

    // 2: in_valid toggling
    step_a(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step_a(0, 0, 1);
      chk_input_a("t2", i);
      if (i != 7) begin
        step_a(0, 0, 0);
        chk("t2_gap_busy", 32'(a_busy), 32'(1));
        chk("t2_gap_wr_en", 32'(a_we), 32'(0));
      end
    end
    step_a(0, 0, 0);
    chk("t2_done", 32'(a_done), 32'(1));

    // 3: reset mid-run
    step_a(0, 1, 0);
    for (int i = 0; i < 3; i++) step_a(0, 0, 1);
    step_a(1, 0, 0);
    step_a(0, 0, 0);
    chk("t3_busy", 32'(a_busy), 32'(0));
    chk("t3_wr_en", 32'(a_we), 32'(0));
    chk("t3_done", 32'(a_done), 32'(0));
    step_a(0, 1, 0);
    step_a(0, 0, 1);
    chk("t3_restart_src", 32'(a_ws), 32'(0));
    chk("t3_restart_addr", 32'(a_wr), 32'(0));
    step_a(1, 0, 0);
    step_a(0, 0, 0);

    // 4: start ignored in RUN, in_valid ignored in DONE/IDLE
    step_a(0, 1, 0);
    step_a(0, 0, 1);
    step_a(0, 1, 1);
    step_a(0, 0, 1);
    chk("t4_in3_addr", 32'(a_wr), 32'(1));
    chk("t4_in3_src", 32'(a_ws), 32'(0));
    for (int i = 3; i < 8; i++) step_a(0, 0, 1);
    step_a(0, 0, 1);
    chk("t4_done_cyc_done", 32'(a_done), 32'(1));
    chk("t4_done_cyc_wr_en", 32'(a_we), 32'(0));
    step_a(0, 0, 1);
    chk("t4_idle_wr_en", 32'(a_we), 32'(0));
    chk("t4_idle_out_val", 32'(a_ov), 32'(0));
    step_a(0, 1, 0);
    step_a(0, 0, 1);
    chk("t4_fresh_src", 32'(a_ws), 32'(0));
    chk("t4_fresh_addr", 32'(a_wr), 32'(0));
    for (int i = 1; i < 8; i++) step_a(0, 0, 1);
    step_a(0, 0, 0);
    step_a(0, 0, 0);

    // 5: full 8x8 map, a gap every 7th cycle
    ov_cnt = 0;
    done_cnt = 0;
    step_b(0, 1, 0);
    for (int i = 0; i < 64; i++) begin
      if (i % 7 == 3) step_b(0, 0, 0);
      step_b(0, 0, 1);
      if (b_ov) begin
        chk("t5_out_row", 32'(b_orow), 32'(ov_cnt / 4));
        chk("t5_out_col", 32'(b_ocol), 32'(ov_cnt % 4));
        ov_cnt++;
      end
      if (b_done) done_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      step_b(0, 0, 0);
      if (b_done) done_cnt++;
    end
    chk("t5_out_valid_count", 32'(ov_cnt), 32'(16));
    chk("t5_done_pulses", 32'(done_cnt), 32'(1));

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
